fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 112 +++++++++++
 tb/tb_fetch_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: one outstanding request at a time, pushes fetched
// slots into the instruction FIFO. Define FETCH_DUAL_ISSUE_EN to fetch two slots per aligned beat.
module fetch_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_address,
  input  logic        branch_taken,
  input  logic        exception_taken,
  input  logic        fifo_full,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [63:0] inst_rdata,
  output logic        pc_en,
  output logic        inst_ok_1,
  output logic        inst_ok_2,
  output logic        fifo_push,
  output logic [31:0] fifo_pc,
  output logic [63:0] fifo_inst,
  output logic        fifo_valid_2,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_DROP
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        redirect;
  logic        accept;
  logic        dual;
  logic [31:0] advance;

`ifdef FETCH_DUAL_ISSUE_EN
  assign dual = ~req_pc_q[2];
`else
  assign dual = 1'b0;
`endif

  assign redirect = branch_taken | exception_taken;
  assign advance  = dual ? 32'd8 : 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      req_pc_q <= 32'hbfc0_0000;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    req_pc_d = req_pc_q;
    accept   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_full && !redirect) begin
          req_pc_d = pc_address;
          state_d  = S_ADDR;
        end
      end
      S_ADDR: begin
        if (inst_addr_ok) begin
          state_d = redirect ? S_DROP : S_DATA;
        end else if (redirect) begin
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        // A redirect always wins over returning data; the data is stale.
        if (redirect) begin
          state_d = inst_data_ok ? S_IDLE : S_DROP;
        end else if (inst_data_ok) begin
          accept = 1'b1;
          if (!fifo_full) begin
            req_pc_d = pc_address + advance;
            state_d  = S_ADDR;
          end else begin
            state_d  = S_IDLE;
          end
        end
      end
      S_DROP: begin
        if (inst_data_ok) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    inst_req     = ~rst & (state_q == S_ADDR);
    inst_addr    = req_pc_q;
    busy         = ~rst & (state_q != S_IDLE);
    fifo_push    = ~rst & accept;
    pc_en        = ~rst & (accept | redirect);
    inst_ok_1    = fifo_push;
    inst_ok_2    = fifo_push & dual;
    fifo_valid_2 = inst_ok_2;
    fifo_pc      = fifo_push ? req_pc_q : '0;
    fifo_inst    = fifo_push ? inst_rdata : '0;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a per-cycle vector table plus hand-written
// sequences for dual-slot, redirect-in-DATA, exception-in-ADDR and reset corners.
module tb_fetch_sequencer;

`ifdef FETCH_DUAL_ISSUE_EN
  localparam logic DUAL = 1'b1;
`else
  localparam logic DUAL = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] pc_address;
  logic        branch_taken, exception_taken, fifo_full;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [63:0] inst_rdata;
  logic        pc_en, inst_ok_1, inst_ok_2, fifo_push;
  logic [31:0] fifo_pc;
  logic [63:0] fifo_inst;
  logic        fifo_valid_2, busy;

  int errors = 0;
  int checks = 0;

  fetch_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .pc_address      (pc_address),
    .branch_taken    (branch_taken),
    .exception_taken (exception_taken),
    .fifo_full       (fifo_full),
    .inst_req        (inst_req),
    .inst_addr       (inst_addr),
    .inst_addr_ok    (inst_addr_ok),
    .inst_data_ok    (inst_data_ok),
    .inst_rdata      (inst_rdata),
    .pc_en           (pc_en),
    .inst_ok_1       (inst_ok_1),
    .inst_ok_2       (inst_ok_2),
    .fifo_push       (fifo_push),
    .fifo_pc         (fifo_pc),
    .fifo_inst       (fifo_inst),
    .fifo_valid_2    (fifo_valid_2),
    .busy            (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] pc;
    logic        br, ex, full, aok, dok;
    logic [63:0] rd;
    logic        req;
    logic [31:0] addr;
    logic        pcen, ok1, push;
    logic [31:0] fpc;
    logic [63:0] finst;
    logic        busy;
  } vec_t;

  vec_t vecs[$];

  localparam logic [63:0] RD1 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] RD2 = 64'h5555_6666_7777_8888;
  localparam logic [63:0] RD3 = 64'h9999_aaaa_bbbb_cccc;
  localparam logic [63:0] RD4 = 64'hdead_beef_cafe_f00d;

  task automatic add(input logic [31:0] pc, input logic br, ex, full, aok, dok,
                     input logic [63:0] rd, input logic req, input logic [31:0] addr,
                     input logic pcen, ok1, push, input logic [31:0] fpc,
                     input logic [63:0] finst, input logic bsy);
    vec_t v;
    v.pc = pc; v.br = br; v.ex = ex; v.full = full; v.aok = aok; v.dok = dok; v.rd = rd;
    v.req = req; v.addr = addr; v.pcen = pcen; v.ok1 = ok1; v.push = push;
    v.fpc = fpc; v.finst = finst; v.busy = bsy;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    branch_taken    = 1'b0;
    exception_taken = 1'b0;
    inst_addr_ok    = 1'b0;
    inst_data_ok    = 1'b0;
    fifo_full       = 1'b0;
    inst_rdata      = '0;
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    pc_address = 32'h0000_1004;
    clear_in();

    // pc        br ex fu ao do rd   req addr          pe o1 pu fpc           finst busy
    add(32'h1004, 0, 0, 1, 0, 0, '0, 0, 32'hbfc0_0000, 0, 0, 0, 32'h0,        '0,  0);
    add(32'h1004, 0, 0, 0, 0, 0, '0, 0, 32'hbfc0_0000, 0, 0, 0, 32'h0,        '0,  0);
    add(32'h1004, 0, 0, 0, 0, 0, '0, 1, 32'h1004,      0, 0, 0, 32'h0,        '0,  1);
    add(32'h1004, 0, 0, 0, 1, 0, '0, 1, 32'h1004,      0, 0, 0, 32'h0,        '0,  1);
    add(32'h1004, 0, 0, 0, 0, 0, '0, 0, 32'h1004,      0, 0, 0, 32'h0,        '0,  1);
    add(32'h2000, 0, 0, 0, 0, 1, RD1, 0, 32'h1004,     1, 1, 1, 32'h1004,     RD1, 1);
    add(32'h2000, 0, 0, 0, 1, 0, '0, 1, 32'h2004,      0, 0, 0, 32'h0,        '0,  1);
    add(32'h3000, 0, 0, 1, 0, 1, RD2, 0, 32'h2004,     1, 1, 1, 32'h2004,     RD2, 1);
    add(32'h3000, 0, 0, 1, 0, 0, '0, 0, 32'h2004,      0, 0, 0, 32'h0,        '0,  0);
    add(32'h3004, 0, 0, 0, 0, 0, '0, 0, 32'h2004,      0, 0, 0, 32'h0,        '0,  0);
    add(32'h3004, 1, 0, 0, 0, 0, '0, 1, 32'h3004,      1, 0, 0, 32'h0,        '0,  1);
    add(32'h4004, 0, 0, 0, 0, 0, '0, 0, 32'h3004,      0, 0, 0, 32'h0,        '0,  0);
    add(32'h4004, 0, 1, 0, 1, 0, '0, 1, 32'h4004,      1, 0, 0, 32'h0,        '0,  1);
    add(32'h4004, 1, 0, 0, 0, 0, '0, 0, 32'h4004,      1, 0, 0, 32'h0,        '0,  1);
    add(32'h4004, 0, 0, 0, 0, 1, RD3, 0, 32'h4004,     0, 0, 0, 32'h0,        '0,  1);
    add(32'h5004, 0, 0, 0, 0, 0, '0, 0, 32'h4004,      0, 0, 0, 32'h0,        '0,  0);
    add(32'h5004, 0, 0, 0, 1, 0, '0, 1, 32'h5004,      0, 0, 0, 32'h0,        '0,  1);
    add(32'h5004, 1, 0, 0, 0, 1, RD3, 0, 32'h5004,     1, 0, 0, 32'h0,        '0,  1);
    add(32'h6004, 0, 0, 0, 0, 0, '0, 0, 32'h5004,      0, 0, 0, 32'h0,        '0,  0);
    add(32'h6004, 0, 0, 0, 1, 0, '0, 1, 32'h6004,      0, 0, 0, 32'h0,        '0,  1);
    add(32'h7000, 0, 0, 0, 0, 1, RD4, 0, 32'h6004,     1, 1, 1, 32'h6004,     RD4, 1);
    add(32'h7000, 0, 0, 0, 0, 0, '0, 1, 32'h7004,      0, 0, 0, 32'h0,        '0,  1);

    tick();
    tick();
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      pc_address      = vecs[i].pc;
      branch_taken    = vecs[i].br;
      exception_taken = vecs[i].ex;
      fifo_full       = vecs[i].full;
      inst_addr_ok    = vecs[i].aok;
      inst_data_ok    = vecs[i].dok;
      inst_rdata      = vecs[i].rd;
      settle();
      chk($sformatf("v%0d inst_req", i),     64'(inst_req),     64'(vecs[i].req));
      chk($sformatf("v%0d inst_addr", i),    64'(inst_addr),    64'(vecs[i].addr));
      chk($sformatf("v%0d pc_en", i),        64'(pc_en),        64'(vecs[i].pcen));
      chk($sformatf("v%0d inst_ok_1", i),    64'(inst_ok_1),    64'(vecs[i].ok1));
      chk($sformatf("v%0d inst_ok_2", i),    64'(inst_ok_2),    64'(0));
      chk($sformatf("v%0d fifo_push", i),    64'(fifo_push),    64'(vecs[i].push));
      chk($sformatf("v%0d fifo_pc", i),      64'(fifo_pc),      64'(vecs[i].fpc));
      chk($sformatf("v%0d fifo_inst", i),    fifo_inst,         vecs[i].finst);
      chk($sformatf("v%0d fifo_valid_2", i), 64'(fifo_valid_2), 64'(0));
      chk($sformatf("v%0d busy", i),         64'(busy),         64'(vecs[i].busy));
      tick();
    end

    // Aligned boot fetch: second slot only with dual issue.
    do_reset();
    pc_address = 32'hbfc0_0000;
    settle();
    chk("boot idle busy", 64'(busy), 64'(0));
    chk("boot idle addr", 64'(inst_addr), 64'(32'hbfc0_0000));
    tick();
    inst_addr_ok = 1'b1;
    settle();
    chk("boot req", 64'(inst_req), 64'(1));
    chk("boot addr", 64'(inst_addr), 64'(32'hbfc0_0000));
    tick();
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1;
    inst_rdata   = RD1;
    settle();
    chk("boot push", 64'(fifo_push), 64'(1));
    chk("boot fifo_pc", 64'(fifo_pc), 64'(32'hbfc0_0000));
    chk("boot fifo_inst", fifo_inst, RD1);
    chk("boot ok_1", 64'(inst_ok_1), 64'(1));
    chk("boot ok_2", 64'(inst_ok_2), 64'(DUAL));
    chk("boot valid_2", 64'(fifo_valid_2), 64'(DUAL));
    chk("boot pc_en", 64'(pc_en), 64'(1));
    tick();
    inst_data_ok = 1'b0;
    settle();
    chk("boot next req", 64'(inst_req), 64'(1));
    chk("boot next addr", 64'(inst_addr), 64'(DUAL ? 32'hbfc0_0008 : 32'hbfc0_0004));
    tick();

    // Unaligned fetch never delivers a second slot.
    do_reset();
    pc_address = 32'hbfc0_0004;
    tick();
    inst_addr_ok = 1'b1;
    settle();
    chk("unal addr", 64'(inst_addr), 64'(32'hbfc0_0004));
    tick();
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1;
    inst_rdata   = RD2;
    settle();
    chk("unal push", 64'(fifo_push), 64'(1));
    chk("unal fifo_pc", 64'(fifo_pc), 64'(32'hbfc0_0004));
    chk("unal ok_2", 64'(inst_ok_2), 64'(0));
    chk("unal valid_2", 64'(fifo_valid_2), 64'(0));
    tick();
    inst_data_ok = 1'b0;
    settle();
    chk("unal next req", 64'(inst_req), 64'(1));
    chk("unal next addr", 64'(inst_addr), 64'(32'hbfc0_0008));

    // Branch in DATA, data returns three cycles later and is dropped.
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    branch_taken = 1'b1;
    pc_address   = 32'h8004;
    settle();
    chk("br pc_en", 64'(pc_en), 64'(1));
    chk("br ok_1", 64'(inst_ok_1), 64'(0));
    chk("br push", 64'(fifo_push), 64'(0));
    tick();
    branch_taken = 1'b0;
    for (int k = 0; k < 2; k++) begin
      settle();
      chk($sformatf("drop%0d req", k), 64'(inst_req), 64'(0));
      chk($sformatf("drop%0d busy", k), 64'(busy), 64'(1));
      chk($sformatf("drop%0d pc_en", k), 64'(pc_en), 64'(0));
      tick();
    end
    inst_data_ok = 1'b1;
    inst_rdata   = RD3;
    settle();
    chk("drop data push", 64'(fifo_push), 64'(0));
    chk("drop data pc_en", 64'(pc_en), 64'(0));
    chk("drop data busy", 64'(busy), 64'(1));
    tick();
    inst_data_ok = 1'b0;
    settle();
    chk("post drop busy", 64'(busy), 64'(0));
    tick();
    settle();
    chk("redirect req", 64'(inst_req), 64'(1));
    chk("redirect addr", 64'(inst_addr), 64'(32'h8004));

    // Exception in ADDR before address acceptance withdraws the request.
    exception_taken = 1'b1;
    tick();
    exception_taken = 1'b0;
    fifo_full       = 1'b1;
    settle();
    chk("exc req", 64'(inst_req), 64'(0));
    chk("exc busy", 64'(busy), 64'(0));
    chk("exc push", 64'(fifo_push), 64'(0));
    tick();

    // Reset in DATA, coinciding with data, then a late data_ok.
    fifo_full  = 1'b0;
    pc_address = 32'h9004;
    tick();
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    settle();
    chk("rst pre busy", 64'(busy), 64'(1));
    rst          = 1'b1;
    inst_data_ok = 1'b1;
    inst_rdata   = RD4;
    #1;
    chk("rst prio push", 64'(fifo_push), 64'(0));
    chk("rst prio pc_en", 64'(pc_en), 64'(0));
    tick();
    rst          = 1'b0;
    inst_data_ok = 1'b0;
    fifo_full    = 1'b1;
    settle();
    chk("rst req", 64'(inst_req), 64'(0));
    chk("rst busy", 64'(busy), 64'(0));
    chk("rst push", 64'(fifo_push), 64'(0));
    chk("rst pc_en", 64'(pc_en), 64'(0));
    chk("rst ok_1", 64'(inst_ok_1), 64'(0));
    chk("rst ok_2", 64'(inst_ok_2), 64'(0));
    chk("rst valid_2", 64'(fifo_valid_2), 64'(0));
    chk("rst fifo_pc", 64'(fifo_pc), 64'(0));
    chk("rst fifo_inst", fifo_inst, 64'(0));
    chk("rst addr", 64'(inst_addr), 64'(32'hbfc0_0000));
    tick();
    inst_data_ok = 1'b1;
    settle();
    chk("late push", 64'(fifo_push), 64'(0));
    chk("late pc_en", 64'(pc_en), 64'(0));
    chk("late busy", 64'(busy), 64'(0));
    chk("late fifo_inst", fifo_inst, 64'(0));
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
